// File: rtl/pulse_proto_pkg.sv
// Shared definitions for the pulse-distance link: FSM state encoding, default
// timing (matching rx) and a frame-length helper.
package pulse_proto_pkg;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_SYNC_BURST   = 4'd1,
        ST_SYNC_SILENCE = 4'd2,
        ST_BIT_BURST    = 4'd3,
        ST_BIT_SILENCE  = 4'd4,
        ST_FINAL_BURST  = 4'd5
    } tx_state_e;

    localparam int DEF_SBD            = 1000;
    localparam int DEF_SSD            = 1000;
    localparam int DEF_BBD            = 500;
    localparam int DEF_BSD0           = 250;
    localparam int DEF_BSD1           = 500;
    localparam int DEF_WIDTH          = 128;
    localparam int DEF_CARRIER_PERIOD = 4;

    function automatic int max_dur(input int a, input int b, input int c,
                                   input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // Cycles from accept to the done edge for a code containing n_ones set bits.
    function automatic int frame_cycles(input int sbd, input int ssd, input int bbd,
                                        input int bsd0, input int bsd1,
                                        input int width, input int n_ones);
        return sbd + ssd + width * bbd + n_ones * bsd1 + (width - n_ones) * bsd0 + bbd;
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Load-and-count-down duration counter; expired_out is high while the count reads zero.
module pulse_timer
    import pulse_proto_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         load_in,
    input  logic [W-1:0] value_in,
    output logic         expired_out
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_count <= '0;
        end else if (load_in) begin
            r_count <= value_in;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign expired_out = (r_count == '0);

endmodule

// File: rtl/pulse_tx.sv
// Pulse-distance transmitter: sync burst/silence, MSB-first bit bursts with
// 0/1-dependent silences, closing burst. Optional carrier via PULSE_TX_CARRIER_EN.
module pulse_tx
    import pulse_proto_pkg::*;
#(
    parameter int SBD            = DEF_SBD,
    parameter int SSD            = DEF_SSD,
    parameter int BBD            = DEF_BBD,
    parameter int BSD0           = DEF_BSD0,
    parameter int BSD1           = DEF_BSD1,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int CARRIER_PERIOD = DEF_CARRIER_PERIOD
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] code_in,
    input  logic             trigger_in,
    output logic             signal_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [3:0]       state_out
);

    localparam int DUR_MAX = max_dur(SBD, SSD, BBD, BSD0, BSD1);
    localparam int CW      = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;
    localparam int BW      = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] L_SBD  = CW'(SBD - 1);
    localparam logic [CW-1:0] L_SSD  = CW'(SSD - 1);
    localparam logic [CW-1:0] L_BBD  = CW'(BBD - 1);
    localparam logic [CW-1:0] L_BSD0 = CW'(BSD0 - 1);
    localparam logic [CW-1:0] L_BSD1 = CW'(BSD1 - 1);

    if (SBD < 1 || SSD < 1 || BBD < 1 || BSD0 < 1 || BSD1 < 1 || WIDTH < 1) begin : g_bad_cfg
        $error("pulse_tx: all durations and WIDTH must be >= 1");
    end
    if (CARRIER_PERIOD < 2 || (CARRIER_PERIOD % 2) != 0) begin : g_bad_carrier
        $error("pulse_tx: CARRIER_PERIOD must be even and >= 2");
    end

    tx_state_e        r_state, w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [BW-1:0]    r_bits;
    logic             r_bit_sel;
    logic             r_signal;
    logic             r_done;
    logic             w_load;
    logic [CW-1:0]    w_value;
    logic             w_expired;
    logic             w_accept;
    logic             w_burst_next;

    pulse_timer #(.W(CW)) u_timer (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     (w_load),
        .value_in    (w_value),
        .expired_out (w_expired)
    );

    assign w_accept     = (r_state == ST_IDLE) && trigger_in;
    assign w_shift_next = r_shift << 1;
    assign w_burst_next = (w_state_next == ST_SYNC_BURST) || (w_state_next == ST_BIT_BURST) ||
                          (w_state_next == ST_FINAL_BURST);

    // Every transition into a timed phase reloads the timer with that phase's length-1.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_value      = '0;
        case (r_state)
            ST_IDLE: if (trigger_in) begin
                w_state_next = ST_SYNC_BURST;
                w_load       = 1'b1;
                w_value      = L_SBD;
            end
            ST_SYNC_BURST: if (w_expired) begin
                w_state_next = ST_SYNC_SILENCE;
                w_load       = 1'b1;
                w_value      = L_SSD;
            end
            ST_SYNC_SILENCE: if (w_expired) begin
                w_state_next = ST_BIT_BURST;
                w_load       = 1'b1;
                w_value      = L_BBD;
            end
            ST_BIT_BURST: if (w_expired) begin
                w_state_next = ST_BIT_SILENCE;
                w_load       = 1'b1;
                w_value      = r_bit_sel ? L_BSD1 : L_BSD0;
            end
            ST_BIT_SILENCE: if (w_expired) begin
                w_state_next = (r_bits == BW'(1)) ? ST_FINAL_BURST : ST_BIT_BURST;
                w_load       = 1'b1;
                w_value      = L_BBD;
            end
            ST_FINAL_BURST: if (w_expired) begin
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bits    <= '0;
            r_bit_sel <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == ST_FINAL_BURST) && w_expired;
            if (w_accept) begin
                r_shift <= code_in;
                r_bits  <= BW'(WIDTH);
            end else if (r_state == ST_BIT_SILENCE && w_expired) begin
                r_shift <= w_shift_next;
                r_bits  <= r_bits - BW'(1);
            end
            // Silence length is fixed by the MSB seen as each bit burst begins.
            if (r_state == ST_SYNC_SILENCE && w_expired) begin
                r_bit_sel <= r_shift[WIDTH-1];
            end else if (r_state == ST_BIT_SILENCE && w_expired) begin
                r_bit_sel <= w_shift_next[WIDTH-1];
            end
        end
    end

`ifdef PULSE_TX_CARRIER_EN
    localparam int PW = (CARRIER_PERIOD > 2) ? $clog2(CARRIER_PERIOD) : 1;
    localparam logic [PW-1:0] CAR_LAST = PW'(CARRIER_PERIOD - 1);
    localparam logic [PW-1:0] CAR_HALF = PW'(CARRIER_PERIOD / 2);

    logic [PW-1:0] r_car_cnt;
    logic [PW-1:0] w_car_cnt_next;
    logic          w_burst_entry;

    assign w_burst_entry  = w_burst_next && (w_state_next != r_state);
    assign w_car_cnt_next = (r_car_cnt == CAR_LAST) ? '0 : r_car_cnt + PW'(1);

    // Carrier phase restarts high on every burst entry.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_car_cnt <= '0;
            r_signal  <= 1'b0;
        end else if (w_burst_entry) begin
            r_car_cnt <= '0;
            r_signal  <= 1'b1;
        end else if (w_burst_next) begin
            r_car_cnt <= w_car_cnt_next;
            r_signal  <= (w_car_cnt_next < CAR_HALF);
        end else begin
            r_car_cnt <= '0;
            r_signal  <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_signal <= 1'b0;
        end else begin
            r_signal <= w_burst_next;
        end
    end
`endif

    assign signal_out = r_signal;
    assign busy_out   = (r_state != ST_IDLE);
    assign done_out   = r_done;
    assign state_out  = r_state;

endmodule

// File: tb/tb_pulse_tx.sv
// Directed bench for pulse_tx with small timing: expected burst/silence runs
// are queued when a frame is triggered and popped as the line is observed.
module tb_pulse_tx;
    import pulse_proto_pkg::*;

    localparam int T_SBD  = 20;
    localparam int T_SSD  = 20;
    localparam int T_BBD  = 10;
    localparam int T_BSD0 = 5;
    localparam int T_BSD1 = 10;
    localparam int T_W    = 8;

    typedef struct {
        logic lvl;
        int   len;
    } seg_t;

    logic           clk;
    logic           rst_in;
    logic [T_W-1:0] code_in;
    logic           trigger_in;
    logic           signal_out;
    logic           busy_out;
    logic           done_out;
    logic [3:0]     state_out;

    int   checks = 0;
    int   errors = 0;
    seg_t exp_q[$];
    int   exp_len_q[$];

    pulse_tx #(
        .SBD(T_SBD), .SSD(T_SSD), .BBD(T_BBD), .BSD0(T_BSD0), .BSD1(T_BSD1),
        .WIDTH(T_W), .CARRIER_PERIOD(4)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst_in),
        .code_in    (code_in),
        .trigger_in (trigger_in),
        .signal_out (signal_out),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .state_out  (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard entry: the run-length sequence and total length of one frame.
    task automatic push_frame(input logic [T_W-1:0] code);
        logic [T_W-1:0] c;
        c = code;
        exp_q.push_back('{1'b1, T_SBD});
        exp_q.push_back('{1'b0, T_SSD});
        for (int i = T_W - 1; i >= 0; i--) begin
            exp_q.push_back('{1'b1, T_BBD});
            exp_q.push_back('{1'b0, c[i] ? T_BSD1 : T_BSD0});
        end
        exp_q.push_back('{1'b1, T_BBD});
        exp_len_q.push_back(frame_cycles(T_SBD, T_SSD, T_BBD, T_BSD0, T_BSD1, T_W, $countones(code)));
    endtask

    task automatic check_seg(input logic lvl, input int len);
        seg_t s;
        check("seg_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            check("seg_level", lvl, s.lvl);
            check("seg_len", len, s.len);
        end
    endtask

    // Called on a negedge: request a frame, return on the first sample after accept.
    task automatic start(input logic [T_W-1:0] code);
        code_in    = code;
        trigger_in = 1'b1;
        push_frame(code);
        @(negedge clk);
        trigger_in = 1'b0;
        check("start_state", state_out, 1);
        check("start_busy", busy_out, 1);
    endtask

    // Samples one frame. poke_at: sample index at which a stray trigger and a
    // new code are driven. chain: trigger the next frame in the done cycle.
    task automatic collect(input logic [T_W-1:0] code, input int poke_at, input bit chain,
                           input logic [T_W-1:0] chain_code, output int n);
        logic cur;
        int   run;
        bit   done_seen;
        int   exp_len;
        cur = 1'b1;
        run = 0;
        n = 0;
        done_seen = 1'b0;
        for (int guard = 0; guard < 2000 && !done_seen; guard++) begin
            if (done_out === 1'b1) begin
                done_seen = 1'b1;
            end else begin
                n++;
                if (signal_out === cur) begin
                    run++;
                end else begin
                    check_seg(cur, run);
                    cur = signal_out;
                    run = 1;
                end
                trigger_in = (n == poke_at);
                if (n == poke_at) code_in = '0;
                @(negedge clk);
            end
        end
        check("frame_timeout", done_seen, 1);
        check_seg(cur, run);
        exp_len = exp_len_q.size() > 0 ? exp_len_q.pop_front() : -1;
        check("frame_len", n, exp_len);
        check("done_signal", signal_out, 0);
        check("done_state", state_out, 0);
        check("done_busy", busy_out, 0);
        check("segs_left", exp_q.size(), 0);
        $display("frame code=%02h cycles=%0d", code, n);
        if (chain) begin
            code_in    = chain_code;
            trigger_in = 1'b1;
            push_frame(chain_code);
            @(negedge clk);
            trigger_in = 1'b0;
            check("done_one_cycle", done_out, 0);
            check("chain_state", state_out, 1);
        end else begin
            @(negedge clk);
            check("done_one_cycle", done_out, 0);
            check("idle_after", busy_out, 0);
        end
    endtask

    initial begin
        int n;
        int bb;
        int done_cnt;
        int busy_cnt;
        logic [3:0] prev_state;

        rst_in     = 1'b1;
        trigger_in = 1'b0;
        code_in    = '0;
        repeat (3) @(negedge clk);
        check("rst_signal", signal_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_state", state_out, 0);
        rst_in = 1'b0;
        @(negedge clk);
        check("idle_state", state_out, 0);

        // Basic 8'hBA frame: silences 10,5,10,10,10,5,10,5; 195 cycles.
        start(8'hBA);
        collect(8'hBA, 0, 1'b0, '0, n);
        check("ba_len_195", n, 195);

        // Stray trigger plus code change at cycle 50 must not disturb the frame.
        start(8'hBA);
        collect(8'hBA, 50, 1'b0, '0, n);
        busy_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy_out !== 1'b0) busy_cnt++;
        end
        check("no_second_frame", busy_cnt, 0);

        // Back-to-back frames: trigger in the done cycle.
        start(8'h5C);
        collect(8'h5C, 0, 1'b1, 8'hA5, n);
        collect(8'hA5, 0, 1'b0, '0, n);

        // Reset during the 4th bit burst.
        start(8'hBA);
        bb = 0;
        prev_state = 4'd0;
        for (int guard = 0; guard < 500 && bb < 4; guard++) begin
            if (state_out == 4'd3 && prev_state != 4'd3) bb++;
            prev_state = state_out;
            if (bb < 4) @(negedge clk);
        end
        check("bb4_reached", bb, 4);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        check("midrst_signal", signal_out, 0);
        check("midrst_state", state_out, 0);
        check("midrst_busy", busy_out, 0);
        check("midrst_done", done_out, 0);
        exp_q.delete();
        exp_len_q.delete();
        done_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_out !== 1'b0) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);

        start(8'h3C);
        collect(8'h3C, 0, 1'b0, '0, n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
